periph_bus_arbiter: RTL and testbench

Two-master arbiter for the single-cycle peripheral bus used by the memory-mapped peripherals (LED, timers, UART). It shares one slave-side bus port between master 0 (CPU load/store unit) and master 1 (debug/DMA port) with round-robin priority. It forwards the granted master's request combinationally and tracks read ownership so returned read data reaches only the issuing master.

---
 rtl/periph_bus_arbiter_if.sv | 45 ++++
 rtl/periph_bus_arbiter.sv | 104 ++++++++++
 tb/tb_periph_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_if.sv
// Bus bundle around the two-master arbiter: both master request/response
// channels plus the shared slave-side port. The arbiter takes the slave
// modport; the environment (masters and peripheral) takes the master modport.
interface periph_bus_arbiter_if;
  logic        m0_write_req;
  logic        m0_read_req;
  logic [31:0] m0_write_data;
  logic [3:0]  m0_byte_enable;
  logic        m0_gnt;
  logic [31:0] m0_read_data;
  logic        m0_read_data_valid;

  logic        m1_write_req;
  logic        m1_read_req;
  logic [31:0] m1_write_data;
  logic [3:0]  m1_byte_enable;
  logic        m1_gnt;
  logic [31:0] m1_read_data;
  logic        m1_read_data_valid;

  logic        s_write_req;
  logic        s_read_req;
  logic [31:0] s_write_data;
  logic [3:0]  s_byte_enable;
  logic [31:0] s_read_data;
  logic        s_read_data_valid;

  modport slave (
    input  m0_write_req, m0_read_req, m0_write_data, m0_byte_enable,
    output m0_gnt, m0_read_data, m0_read_data_valid,
    input  m1_write_req, m1_read_req, m1_write_data, m1_byte_enable,
    output m1_gnt, m1_read_data, m1_read_data_valid,
    output s_write_req, s_read_req, s_write_data, s_byte_enable,
    input  s_read_data, s_read_data_valid
  );

  modport master (
    output m0_write_req, m0_read_req, m0_write_data, m0_byte_enable,
    input  m0_gnt, m0_read_data, m0_read_data_valid,
    output m1_write_req, m1_read_req, m1_write_data, m1_byte_enable,
    input  m1_gnt, m1_read_data, m1_read_data_valid,
    input  s_write_req, s_read_req, s_write_data, s_byte_enable,
    output s_read_data, s_read_data_valid
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the single-cycle peripheral bus.
// Grant and forwarding are combinational; a READ_LATENCY-deep tag pipeline
// remembers which master issued each read so returned data is flagged valid
// only toward that master. Legal READ_LATENCY range is 1..4.
module periph_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  periph_bus_arbiter_if.slave  bus,
  output logic                 err_unexpected
);

  logic                    r_prio;      // 0: m0 favoured, 1: m1 favoured
  logic [READ_LATENCY-1:0] r_tag_vld;
  logic [READ_LATENCY-1:0] r_tag_id;
  logic                    r_err;

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_read_fwd;
  logic w_tail_vld;
  logic w_tail_id;

  assign w_req0 = bus.m0_write_req | bus.m0_read_req;
  assign w_req1 = bus.m1_write_req | bus.m1_read_req;

  // Grants are gated by reset_n so nothing reaches the slave while in reset.
  assign w_gnt0 = reset_n & w_req0 & (~w_req1 | ~r_prio);
  assign w_gnt1 = reset_n & w_req1 & (~w_req0 |  r_prio);

  assign bus.m0_gnt = w_gnt0;
  assign bus.m1_gnt = w_gnt1;

  // A write+read pair from one master still counts as a read for tracking.
  assign w_read_fwd = (w_gnt0 & bus.m0_read_req) | (w_gnt1 & bus.m1_read_req);

  // Forward the granted master's request and payload; idle bus drives zeros.
  always_comb begin
    bus.s_write_req   = 1'b0;
    bus.s_read_req    = 1'b0;
    bus.s_write_data  = 32'h0;
    bus.s_byte_enable = 4'h0;
    if (w_gnt0) begin
      bus.s_write_req   = bus.m0_write_req;
      bus.s_read_req    = bus.m0_read_req;
      bus.s_write_data  = bus.m0_write_data;
      bus.s_byte_enable = bus.m0_byte_enable;
    end else if (w_gnt1) begin
      bus.s_write_req   = bus.m1_write_req;
      bus.s_read_req    = bus.m1_read_req;
      bus.s_write_data  = bus.m1_write_data;
      bus.s_byte_enable = bus.m1_byte_enable;
    end
  end

  // Round-robin pointer: after any transfer, hand priority to the other master.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end

  // Read-ownership shift register; advances every cycle, one slot per read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      r_tag_vld[0] <= w_read_fwd;
      r_tag_id[0]  <= w_gnt1;
    end
  end

  assign w_tail_vld = r_tag_vld[READ_LATENCY-1];
  assign w_tail_id  = r_tag_id[READ_LATENCY-1];

  // Sticky flag for slave data that arrives with no read outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (bus.s_read_data_valid && !w_tail_vld) begin
      r_err <= 1'b1;
    end
  end

  assign err_unexpected = r_err;

  assign bus.m0_read_data       = bus.s_read_data;
  assign bus.m1_read_data       = bus.s_read_data;
  assign bus.m0_read_data_valid = bus.s_read_data_valid & w_tail_vld & ~w_tail_id;
  assign bus.m1_read_data_valid = bus.s_read_data_valid & w_tail_vld &  w_tail_id;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench: one arbiter with READ_LATENCY=1 and one with READ_LATENCY=3
// share the same master/slave stimulus; each section checks the relevant one.
module tb_periph_bus_arbiter;

  logic clk;
  logic reset_n;
  logic err1;
  logic err3;
  int   checks;
  int   errors;

  periph_bus_arbiter_if b1 ();
  periph_bus_arbiter_if b3 ();

  assign b3.m0_write_req      = b1.m0_write_req;
  assign b3.m0_read_req       = b1.m0_read_req;
  assign b3.m0_write_data     = b1.m0_write_data;
  assign b3.m0_byte_enable    = b1.m0_byte_enable;
  assign b3.m1_write_req      = b1.m1_write_req;
  assign b3.m1_read_req       = b1.m1_read_req;
  assign b3.m1_write_data     = b1.m1_write_data;
  assign b3.m1_byte_enable    = b1.m1_byte_enable;
  assign b3.s_read_data       = b1.s_read_data;
  assign b3.s_read_data_valid = b1.s_read_data_valid;

  periph_bus_arbiter #(.READ_LATENCY(1)) dut1 (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (b1),
    .err_unexpected (err1)
  );

  periph_bus_arbiter #(.READ_LATENCY(3)) dut3 (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (b3),
    .err_unexpected (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.m0_write_req      = 1'b0;
    b1.m0_read_req       = 1'b0;
    b1.m0_write_data     = 32'h0;
    b1.m0_byte_enable    = 4'h0;
    b1.m1_write_req      = 1'b0;
    b1.m1_read_req       = 1'b0;
    b1.m1_write_data     = 32'h0;
    b1.m1_byte_enable    = 4'h0;
    b1.s_read_data       = 32'h0;
    b1.s_read_data_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset_n = 1'b0;

    // Reset: requests present but nothing granted or forwarded.
    #2;
    b1.m0_write_req = 1'b1;
    b1.m1_read_req  = 1'b1;
    #1;
    chk("rst_m0_gnt", {31'b0, b1.m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'b0, b1.m1_gnt}, 32'd0);
    chk("rst_s_wreq", {31'b0, b1.s_write_req}, 32'd0);
    chk("rst_s_rreq", {31'b0, b1.s_read_req}, 32'd0);
    chk("rst_err", {31'b0, err1}, 32'd0);
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;

    // Single master write.
    tick();
    b1.m0_write_req   = 1'b1;
    b1.m0_write_data  = 32'h0000_000A;
    b1.m0_byte_enable = 4'h1;
    #1;
    chk("single_m0_gnt", {31'b0, b1.m0_gnt}, 32'd1);
    chk("single_m1_gnt", {31'b0, b1.m1_gnt}, 32'd0);
    chk("single_s_wreq", {31'b0, b1.s_write_req}, 32'd1);
    chk("single_s_rreq", {31'b0, b1.s_read_req}, 32'd0);
    chk("single_s_wdata", b1.s_write_data, 32'h0000_000A);
    chk("single_s_be", {28'b0, b1.s_byte_enable}, 32'h1);

    // Contention from reset: grants alternate m0,m1,m0,m1.
    tick();
    idle_inputs();
    reset_pulse();
    tick();
    b1.m0_write_req   = 1'b1;
    b1.m0_write_data  = 32'h0000_0100;
    b1.m0_byte_enable = 4'hF;
    b1.m1_write_req   = 1'b1;
    b1.m1_write_data  = 32'h0000_0200;
    b1.m1_byte_enable = 4'h3;
    #1;
    chk("cont0_m0_gnt", {31'b0, b1.m0_gnt}, 32'd1);
    chk("cont0_m1_gnt", {31'b0, b1.m1_gnt}, 32'd0);
    chk("cont0_wdata", b1.s_write_data, 32'h0000_0100);
    tick(); #1;
    chk("cont1_m0_gnt", {31'b0, b1.m0_gnt}, 32'd0);
    chk("cont1_m1_gnt", {31'b0, b1.m1_gnt}, 32'd1);
    chk("cont1_wdata", b1.s_write_data, 32'h0000_0200);
    chk("cont1_be", {28'b0, b1.s_byte_enable}, 32'h3);
    tick(); #1;
    chk("cont2_m0_gnt", {31'b0, b1.m0_gnt}, 32'd1);
    chk("cont2_m1_gnt", {31'b0, b1.m1_gnt}, 32'd0);
    tick(); #1;
    chk("cont3_m0_gnt", {31'b0, b1.m0_gnt}, 32'd0);
    chk("cont3_m1_gnt", {31'b0, b1.m1_gnt}, 32'd1);

    // Idle bus drives zeros.
    tick();
    idle_inputs();
    #1;
    chk("idle_wdata", b1.s_write_data, 32'h0);
    chk("idle_be", {28'b0, b1.s_byte_enable}, 32'h0);
    chk("idle_gnt", {30'b0, b1.m1_gnt, b1.m0_gnt}, 32'd0);

    // Read routing, latency 1: m1 read, data back next cycle.
    reset_pulse();
    tick();
    b1.m1_read_req = 1'b1;
    #1;
    chk("rd1_m1_gnt", {31'b0, b1.m1_gnt}, 32'd1);
    chk("rd1_s_rreq", {31'b0, b1.s_read_req}, 32'd1);
    tick();
    b1.m1_read_req       = 1'b0;
    b1.s_read_data       = 32'h0000_0005;
    b1.s_read_data_valid = 1'b1;
    #1;
    chk("rd1_m1_valid", {31'b0, b1.m1_read_data_valid}, 32'd1);
    chk("rd1_m1_data", b1.m1_read_data, 32'h0000_0005);
    chk("rd1_m0_valid", {31'b0, b1.m0_read_data_valid}, 32'd0);
    tick();
    b1.s_read_data_valid = 1'b0;
    #1;
    chk("rd1_err", {31'b0, err1}, 32'd0);

    // Interleaved reads, latency 3: m0,m1,m0 then returns 1,2,3.
    reset_pulse();
    tick();
    b1.m0_read_req = 1'b1;
    #1;
    chk("rd3_g0", {30'b0, b3.m1_gnt, b3.m0_gnt}, 32'b01);
    tick();
    b1.m0_read_req = 1'b0;
    b1.m1_read_req = 1'b1;
    #1;
    chk("rd3_g1", {30'b0, b3.m1_gnt, b3.m0_gnt}, 32'b10);
    tick();
    b1.m1_read_req = 1'b0;
    b1.m0_read_req = 1'b1;
    #1;
    chk("rd3_g2", {30'b0, b3.m1_gnt, b3.m0_gnt}, 32'b01);
    tick();
    b1.m0_read_req       = 1'b0;
    b1.s_read_data       = 32'h0000_0001;
    b1.s_read_data_valid = 1'b1;
    #1;
    chk("rd3_r0_valids", {30'b0, b3.m1_read_data_valid, b3.m0_read_data_valid}, 32'b01);
    chk("rd3_r0_data", b3.m0_read_data, 32'h0000_0001);
    tick();
    b1.s_read_data = 32'h0000_0002;
    #1;
    chk("rd3_r1_valids", {30'b0, b3.m1_read_data_valid, b3.m0_read_data_valid}, 32'b10);
    chk("rd3_r1_data", b3.m1_read_data, 32'h0000_0002);
    tick();
    b1.s_read_data = 32'h0000_0003;
    #1;
    chk("rd3_r2_valids", {30'b0, b3.m1_read_data_valid, b3.m0_read_data_valid}, 32'b01);
    chk("rd3_r2_data", b3.m0_read_data, 32'h0000_0003);
    tick();
    b1.s_read_data_valid = 1'b0;
    #1;
    chk("rd3_err", {31'b0, err3}, 32'd0);

    // Spurious return with nothing in flight.
    reset_pulse();
    tick();
    b1.s_read_data       = 32'hDEAD_BEEF;
    b1.s_read_data_valid = 1'b1;
    #1;
    chk("spur_valids", {30'b0, b1.m1_read_data_valid, b1.m0_read_data_valid}, 32'b00);
    chk("spur_err_pre", {31'b0, err1}, 32'd0);
    tick();
    b1.s_read_data_valid = 1'b0;
    #1;
    chk("spur_err_set", {31'b0, err1}, 32'd1);
    tick();
    tick();
    #1;
    chk("spur_err_sticky", {31'b0, err1}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("spur_err_clr", {31'b0, err1}, 32'd0);
    reset_n = 1'b1;

    // Reset with an m0 read in flight on the latency-3 arbiter.
    tick();
    b1.m0_read_req = 1'b1;
    #1;
    chk("mid_gnt", {31'b0, b3.m0_gnt}, 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_gnt_rst", {30'b0, b3.m1_gnt, b3.m0_gnt}, 32'b00);
    b1.m0_read_req = 1'b0;
    tick();
    reset_n = 1'b1;
    b1.m0_write_req = 1'b1;
    b1.m1_write_req = 1'b1;
    #1;
    chk("mid_prio0", {30'b0, b3.m1_gnt, b3.m0_gnt}, 32'b01);
    tick();
    b1.m0_write_req      = 1'b0;
    b1.m1_write_req      = 1'b0;
    b1.s_read_data       = 32'h0000_0077;
    b1.s_read_data_valid = 1'b1;
    #1;
    chk("mid_no_valid", {30'b0, b3.m1_read_data_valid, b3.m0_read_data_valid}, 32'b00);
    tick();
    b1.s_read_data_valid = 1'b0;
    #1;
    chk("mid_err", {31'b0, err3}, 32'd1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
